// File: rtl/typing_pkg.sv
// Shared definitions for the typing game: game-state codes seen by both the
// controller and the character checker, PS/2 scancodes, and character codes.
package typing_pkg;

  // Game states; the checker decodes these same values.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_WORD   = 3'b010,
    ST_WRONG  = 3'b011,
    ST_FINISH = 3'b100
  } state_e;

  // Scancodes (set 2) as indexed in the keyboard decoder's key_down bitmap.
  localparam logic [8:0] SC_ENTER = 9'd90;
  localparam logic [8:0] SC_ESC   = 9'd118;
  localparam logic [8:0] SC_SHIFT = 9'h012;
  localparam logic [8:0] SC_BACK  = 9'h066;
  localparam logic [8:0] SC_A = 9'h01C, SC_B = 9'h032, SC_C = 9'h021, SC_D = 9'h023;
  localparam logic [8:0] SC_E = 9'h024, SC_F = 9'h02B, SC_G = 9'h034, SC_H = 9'h033;
  localparam logic [8:0] SC_I = 9'h043, SC_J = 9'h03B, SC_K = 9'h042, SC_L = 9'h04B;
  localparam logic [8:0] SC_M = 9'h03A, SC_N = 9'h031, SC_O = 9'h044, SC_P = 9'h04D;
  localparam logic [8:0] SC_Q = 9'h015, SC_R = 9'h02D, SC_S = 9'h01B, SC_T = 9'h02C;
  localparam logic [8:0] SC_U = 9'h03C, SC_V = 9'h02A, SC_W = 9'h01D, SC_X = 9'h022;
  localparam logic [8:0] SC_Y = 9'h035, SC_Z = 9'h01A;

  // Character codes: 0-25 a-z, 26 space, 27-29 punctuation, 30-55 A-Z.
  typedef logic [5:0] char_t;
  localparam char_t CH_LOWER_FIRST = 6'd0;
  localparam char_t CH_SPACE       = 6'd26;
  localparam char_t CH_COMMA       = 6'd27;
  localparam char_t CH_PERIOD      = 6'd28;
  localparam char_t CH_APOS        = 6'd29;
  localparam char_t CH_UPPER_FIRST = 6'd30;
  localparam char_t CH_UPPER_LAST  = 6'd55;

  // Statistic saturation limits.
  localparam logic [9:0] SEC_MAX     = 10'd999;
  localparam logic [9:0] MISTAKE_MAX = 10'd1023;

endpackage

// File: rtl/typing_game_ctrl_text_rom.sv
// Passage text ROM: combinational 1024 x 6 lookup of character codes.
// Holds "The quick brown fox jumps over the lazy dog, isn't it. Type now."
// in addresses 0..63; every other address reads as a space.
module text_rom
  import typing_pkg::*;
(
  input  logic [9:0] addr,
  output char_t      data
);

  // Constant character table indexed by position in the passage.
  // NOTE: pure combinational lookup with no storage, so there is nothing to reset.
  always_comb begin
    data = CH_SPACE;
    case (addr)
      10'd0:  data = 6'd49; 10'd1:  data = 6'd7;  10'd2:  data = 6'd4;  10'd3:  data = 6'd26;
      10'd4:  data = 6'd16; 10'd5:  data = 6'd20; 10'd6:  data = 6'd8;  10'd7:  data = 6'd2;
      10'd8:  data = 6'd10; 10'd9:  data = 6'd26; 10'd10: data = 6'd1;  10'd11: data = 6'd17;
      10'd12: data = 6'd14; 10'd13: data = 6'd22; 10'd14: data = 6'd13; 10'd15: data = 6'd26;
      10'd16: data = 6'd5;  10'd17: data = 6'd14; 10'd18: data = 6'd23; 10'd19: data = 6'd26;
      10'd20: data = 6'd9;  10'd21: data = 6'd20; 10'd22: data = 6'd12; 10'd23: data = 6'd15;
      10'd24: data = 6'd18; 10'd25: data = 6'd26; 10'd26: data = 6'd14; 10'd27: data = 6'd21;
      10'd28: data = 6'd4;  10'd29: data = 6'd17; 10'd30: data = 6'd26; 10'd31: data = 6'd19;
      10'd32: data = 6'd7;  10'd33: data = 6'd4;  10'd34: data = 6'd26; 10'd35: data = 6'd11;
      10'd36: data = 6'd0;  10'd37: data = 6'd25; 10'd38: data = 6'd24; 10'd39: data = 6'd26;
      10'd40: data = 6'd3;  10'd41: data = 6'd14; 10'd42: data = 6'd6;  10'd43: data = 6'd27;
      10'd44: data = 6'd26; 10'd45: data = 6'd8;  10'd46: data = 6'd18; 10'd47: data = 6'd13;
      10'd48: data = 6'd29; 10'd49: data = 6'd19; 10'd50: data = 6'd26; 10'd51: data = 6'd8;
      10'd52: data = 6'd19; 10'd53: data = 6'd28; 10'd54: data = 6'd26; 10'd55: data = 6'd49;
      10'd56: data = 6'd24; 10'd57: data = 6'd15; 10'd58: data = 6'd4;  10'd59: data = 6'd26;
      10'd60: data = 6'd13; 10'd61: data = 6'd14; 10'd62: data = 6'd22; 10'd63: data = 6'd28;
      default: data = CH_SPACE;
    endcase
  end

endmodule

// File: rtl/typing_game_ctrl.sv
// Typing game top-level sequencer: game FSM driving the checker, expected
// character fetch from the text ROM, 1-second prescaler and round statistics.
// Optional round time limit compiled in with `define TYPING_TIME_LIMIT_EN.
module typing_game_ctrl
  import typing_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TEXT_LEN   = 64,
  parameter int TIME_LIMIT = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         been_ready,
  input  logic [10:0]  word_cnt,
  input  logic         correct_n,
  output logic [2:0]   state,
  output logic [5:0]   word,
  output logic [9:0]   elapsed_sec,
  output logic [9:0]   mistakes,
  output logic         finished
);

  localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [10:0]      TEXT_END = 11'(TEXT_LEN);
`ifdef TYPING_TIME_LIMIT_EN
  localparam logic [9:0]       LIMIT_SEC = 10'(TIME_LIMIT);
`else
  localparam int               unused_time_limit = TIME_LIMIT;
`endif

  state_e           state_q, state_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [9:0]       elapsed_q, elapsed_d;
  logic [9:0]       mistakes_q, mistakes_d;
  char_t            word_q, word_d;
  logic             finished_q, finished_d;

  logic  press_enter, press_esc, in_play;
  char_t rom_data;
  logic  unused_keys;

  // Only ENTER and ESC matter here; the rest of the bitmap belongs to the checker.
  assign unused_keys = ^key_down;

  assign press_enter = been_ready && key_down[SC_ENTER] && (last_change == SC_ENTER);
  assign press_esc   = been_ready && key_down[SC_ESC]   && (last_change == SC_ESC);
  assign in_play     = (state_q == ST_WORD) || (state_q == ST_WRONG);

  text_rom u_text_rom (
    .addr (word_cnt[9:0]),
    .data (rom_data)
  );

  // Next-state logic: prescaler, statistics and prioritised game transitions.
  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    elapsed_d  = elapsed_q;
    mistakes_d = mistakes_q;

    // One-second tick while playing; frozen in FINISH, held at zero in IDLE.
    if (in_play) begin
      if (prescale_q == PRE_LAST) begin
        prescale_d = '0;
        if (elapsed_q != SEC_MAX) elapsed_d = elapsed_q + 10'd1;
      end else begin
        prescale_d = prescale_q + PRE_W'(1);
      end
    end else if (state_q == ST_IDLE) begin
      prescale_d = '0;
    end

    if (state_q != ST_IDLE && press_esc) begin
      state_d = ST_IDLE;
`ifdef TYPING_TIME_LIMIT_EN
    end else if (in_play && elapsed_q == LIMIT_SEC) begin
      state_d = ST_FINISH;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_enter) begin
            state_d    = ST_WORD;
            prescale_d = '0;
            elapsed_d  = '0;
            mistakes_d = '0;
          end
        end
        ST_WORD: begin
          // Completion outranks a pending error on the same cycle.
          if (word_cnt >= TEXT_END) begin
            state_d = ST_FINISH;
          end else if (correct_n) begin
            state_d = ST_WRONG;
            if (mistakes_q != MISTAKE_MAX) mistakes_d = mistakes_q + 10'd1;
          end
        end
        ST_WRONG: begin
          if (!correct_n) state_d = ST_WORD;
        end
        ST_FINISH: begin
          if (press_enter) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    finished_d = (state_d == ST_FINISH);
    // Past the end of the passage the checker is shown a harmless space.
    word_d     = (word_cnt >= TEXT_END) ? CH_SPACE : rom_data;
  end

  // All controller state, including the registered outputs.
  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      elapsed_q  <= '0;
      mistakes_q <= '0;
      word_q     <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      elapsed_q  <= elapsed_d;
      mistakes_q <= mistakes_d;
      word_q     <= word_d;
      finished_q <= finished_d;
    end
  end

  assign state       = state_q;
  assign word        = word_q;
  assign elapsed_sec = elapsed_q;
  assign mistakes    = mistakes_q;
  assign finished    = finished_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Directed bench for typing_game_ctrl with a short passage (TEXT_LEN = 4) and
// a 10-cycle second (CLK_HZ = 10). Inputs change and outputs are sampled on
// the falling edge. Time-limit steps run when TYPING_TIME_LIMIT_EN is defined.
module tb_typing_game_ctrl;

`ifdef TYPING_TIME_LIMIT_EN
  localparam int TB_LIMIT = 6;
`else
  localparam int TB_LIMIT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic [10:0]  word_cnt;
  logic         correct_n;
  logic [2:0]   state;
  logic [5:0]   word;
  logic [9:0]   elapsed_sec;
  logic [9:0]   mistakes;
  logic         finished;

  int total = 0;
  int bad   = 0;

  typing_game_ctrl #(
    .CLK_HZ     (10),
    .TEXT_LEN   (4),
    .TIME_LIMIT (TB_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .been_ready  (been_ready),
    .word_cnt    (word_cnt),
    .correct_n   (correct_n),
    .state       (state),
    .word        (word),
    .elapsed_sec (elapsed_sec),
    .mistakes    (mistakes),
    .finished    (finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int code);
    been_ready       = 1'b1;
    key_down[code]   = 1'b1;
    last_change      = 9'(code);
    step();
    been_ready       = 1'b0;
    key_down         = '0;
  endtask

  initial begin
    rst         = 1'b0;
    key_down    = '0;
    last_change = '0;
    been_ready  = 1'b0;
    word_cnt    = '0;
    correct_n   = 1'b0;

    // Power-on reset values.
    step(2);
    check("rst_state", state, 0);
    check("rst_word", word, 0);
    check("rst_elapsed", elapsed_sec, 0);
    check("rst_mistakes", mistakes, 0);
    check("rst_finished", finished, 0);
    rst = 1'b1;

    step();
    check("idle_hold", state, 0);
    check("word_rom0", word, 49);

    // ENTER starts a round.
    press(90);
    check("enter_to_word", state, 3'b010);
    check("start_elapsed", elapsed_sec, 0);

    // word lags word_cnt by one cycle.
    word_cnt = 11'd1;
    check("word_latency_hold", word, 49);
    step();
    check("word_rom1", word, 7);

    // Three error episodes, each counted once despite 10 cycles in WRONG.
    for (int i = 0; i < 3; i++) begin
      correct_n = 1'b1;
      step();
      check("to_wrong", state, 3'b011);
      check("mistake_inc", mistakes, i + 1);
      step(9);
      check("wrong_hold", state, 3'b011);
      check("mistake_once", mistakes, i + 1);
      correct_n = 1'b0;
      step();
      check("back_to_word", state, 3'b010);
    end
    // 34 cycles in play so far.
    check("elapsed_34cyc", elapsed_sec, 3);

    // Completion and error on the same cycle: FINISH wins, no extra mistake.
    word_cnt  = 11'd4;
    correct_n = 1'b1;
    step();
    check("finish_state", state, 3'b100);
    check("finish_flag", finished, 1);
    check("finish_no_mistake", mistakes, 3);
    check("word_past_end", word, 26);
    correct_n = 1'b0;

    step(100);
    check("finish_hold_state", state, 3'b100);
    check("finish_hold_elapsed", elapsed_sec, 3);

    // ENTER from FINISH returns to IDLE with statistics retained.
    press(90);
    check("finish_to_idle", state, 0);
    check("idle_finished_low", finished, 0);
    check("idle_keep_elapsed", elapsed_sec, 3);
    check("idle_keep_mistakes", mistakes, 3);

    // ESC in IDLE is ignored.
    word_cnt = 11'd0;
    press(118);
    check("esc_in_idle", state, 0);

    // New round clears statistics.
    press(90);
    check("round2_word", state, 3'b010);
    check("round2_elapsed_clr", elapsed_sec, 0);
    check("round2_mistakes_clr", mistakes, 0);

    // ENTER in WORD does nothing.
    press(90);
    check("enter_in_word", state, 3'b010);
    step(34);
    check("elapsed_35cyc", elapsed_sec, 3);

    // ENTER held with ESC as the new event: ESC aborts the round.
    key_down[90]  = 1'b1;
    key_down[118] = 1'b1;
    last_change   = 9'd118;
    been_ready    = 1'b1;
    step();
    been_ready    = 1'b0;
    key_down      = '0;
    check("esc_beats_enter", state, 0);
    check("esc_keep_elapsed", elapsed_sec, 3);

    // Asynchronous reset in the middle of a round.
    press(90);
    word_cnt = 11'd1;
    step();
    word_cnt = 11'd2;
    step();
    word_cnt = 11'd3;
    step();
    correct_n = 1'b1;
    step();
    correct_n = 1'b0;
    step(10);
    check("mid_state", state, 3'b010);
    check("mid_mistakes", mistakes, 1);
    check("mid_elapsed", elapsed_sec, 1);
    check("mid_word", word, 26);
    rst = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_word", word, 0);
    check("async_rst_elapsed", elapsed_sec, 0);
    check("async_rst_mistakes", mistakes, 0);
    step();
    check("rst_held_state", state, 0);
    rst = 1'b1;

`ifdef TYPING_TIME_LIMIT_EN
    // Round ends on the cycle after elapsed_sec reaches the limit.
    word_cnt = 11'd0;
    step();
    press(90);
    check("limit_round_start", state, 3'b010);
    begin
      int n = 0;
      while (elapsed_sec !== 10'(TB_LIMIT) && n < 500) begin
        step();
        n++;
      end
    end
    check("limit_reached", elapsed_sec, TB_LIMIT);
    check("limit_still_word", state, 3'b010);
    step();
    check("limit_finish", state, 3'b100);
    check("limit_finished_flag", finished, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/typing_game_ctrl.md
# typing_game_ctrl

Top-level sequencer for the typing game. Owns the game state machine that drives the character checker's `state` input. Fetches the expected character code (`word`) from a text ROM indexed by the checker's `word_cnt`, and keeps elapsed-time and mistake statistics for the display. Sits between the keyboard decoder and the checker, and feeds the seven-segment/VGA display logic.

## Interface

Parameters:
- `CLK_HZ`, 100_000_000: clock frequency; sets the 1-second prescaler.
- `TEXT_LEN`, 64: number of characters in the passage (1..1023).
- `TIME_LIMIT`, 60: round limit in seconds; only used with `TIME_LIMIT_EN`.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `key_down`  in  512: per-scancode held bitmap from the keyboard decoder.
- `last_change`  in  9: scancode of the most recent key event.
- `been_ready`  in  1: one-cycle pulse marking a new key event.
- `word_cnt`  in  11: checker's count of correct characters.
- `correct_n`  in  1: checker's error flag; 1 means uncorrected wrong input is pending.
- `state`  out  3: game state, routed to the checker.
- `word`  out  6: expected character code. Codes 0-25 are a-z, 26 space, 27 `,`, 28 `.`, 29 `'`, 30-55 A-Z.
- `elapsed_sec`  out  10: seconds spent in play.
- `mistakes`  out  10: count of error events this round.
- `finished`  out  1: high while in FINISH.

## Operation

- State encodings: IDLE=3'b000, WORD=3'b010, WRONG=3'b011, FINISH=3'b100. No other codes are ever driven.
- A key press is defined as `press(k) = been_ready && key_down[k] && last_change == k`. Scancodes: ENTER = 90, ESC = 118.
- Transitions, evaluated in priority order:
  - Any state other than IDLE, on `press(ESC)`: go to IDLE.
  - IDLE, on `press(ENTER)`: go to WORD. Same edge: clear `elapsed_sec`, `mistakes` and the prescaler.
  - WORD, when `word_cnt >= TEXT_LEN`: go to FINISH.
  - WORD, when `correct_n == 1`: go to WRONG. Same edge: `mistakes` += 1, saturating at 1023.
  - WRONG, when `correct_n == 0`: go to WORD.
  - FINISH, on `press(ENTER)`: go to IDLE.
- Time limit (only with `TIME_LIMIT_EN`): in WORD or WRONG, when `elapsed_sec == TIME_LIMIT`, go to FINISH. This ranks below ESC and above all other transitions.
- `word` is registered from `text_rom[word_cnt]`. When `word_cnt >= TEXT_LEN` it is forced to 26 (space).
- Prescaler:
  - Counts 0..`CLK_HZ`-1 only in WORD or WRONG.
  - At terminal count it wraps to 0 and `elapsed_sec` increments, saturating at 999.
  - Holds its value in FINISH; is cleared in IDLE.
- Statistics (`elapsed_sec`, `mistakes`) hold their values through FINISH and IDLE, until the next IDLE→WORD start.
- `finished` is `state == FINISH`, registered together with `state`.

## Timing

- Reset values: `state` = IDLE, `word` = 0, `elapsed_sec` = 0, `mistakes` = 0, `finished` = 0, prescaler = 0.
- Reset is honoured immediately (asynchronous) in any state, including mid-round.
- Latencies:
  - State change takes effect 1 cycle after the qualifying input.
  - `word` follows `word_cnt` with 1 cycle of latency. Key events are far more than 2 cycles apart, so the checker never samples a stale `word`.
  - WORD→WRONG occurs 1 cycle after `correct_n` rises. The checker's `correct_n` is itself registered, so the total is 2 cycles after `cnt_wrong` goes nonzero.
- `mistakes` counts each WORD→WRONG transition exactly once. Extra wrong keys typed while already in WRONG are not counted.
- If ENTER and ESC are pressed in the same cycle, ESC wins.
- `word_cnt` reaching `TEXT_LEN` while `correct_n == 1`: FINISH wins.

## Configuration

- `TYPING_TIME_LIMIT_EN` defined:
  - The time-limit comparator and transition are compiled in.
  - A round ends at `TIME_LIMIT` seconds or on text completion, whichever comes first.
- Not defined:
  - No limit; a round ends only on completion or ESC.
  - `TIME_LIMIT` is ignored.
  - `elapsed_sec` still counts and saturates at 999.

## Structure

- Shared package `typing_pkg` holds:
  - The state encodings (IDLE, WORD, WRONG, FINISH).
  - Scancode constants (ENTER, ESC, SHIFT, BACK, letters).
  - Character-code boundaries (26, 30, 55).
- The checker imports the same package, so the state codes stay consistent.
- One sub-module, `text_rom`: combinational, 1024×6 case/initial table, address 10 bits, data 6 bits.
- The controller contains the FSM, the prescaler, the counters and the `word` register.

## Test plan

- Reset with `rst` = 0 mid-WORD (after 5 correct chars) → next cycle `state` = 0, `elapsed_sec` = 0, `mistakes` = 0, `word` = 0.
- From IDLE, pulse `been_ready` with `last_change` = 90 and `key_down[90]` = 1 → `state` = 3'b010 one cycle later; `word` = ROM[0] one cycle after that.
- In WORD, raise `correct_n` for 10 cycles, then drop it → `state` goes 010→011→010, `mistakes` = 1. Repeating this three times gives `mistakes` = 3.
- `TEXT_LEN` = 4, drive `word_cnt` 0→4 → `state` = 3'b100 and `finished` = 1. Pressing ENTER afterwards → IDLE, with statistics retained.
- `CLK_HZ` = 10, 35 cycles in WORD → `elapsed_sec` = 3. After FINISH, the value stays 3 for 100 further cycles.
- With `TYPING_TIME_LIMIT_EN`, `CLK_HZ` = 4, `TIME_LIMIT` = 2, `correct_n` held at 0 → FINISH on the cycle after `elapsed_sec` reaches 2. Pressing ENTER and ESC together in WORD → IDLE.
